inv_cipher_iter: RTL and testbench
==================================

Name: inv_cipher_iter

Overview:
- Iterative AES inverse cipher (FIPS-197 InvCipher): decrypts one 128-bit block using the expanded key schedule from the existing KeyExpansion block.
- Counterpart of the encrypt datapath. Sits on the receive side of the SPI link, between the SPI slave data register and the plaintext output register.
- Executes one round per clock, with a start/busy/done handshake.

Parameters:
- Nk, 4, key length in 32-bit words (4/6/8); informational, must match KeyExpansion.
- Nr, 10, number of rounds (10/12/14); sets key-schedule width and latency.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- cipher_text  input  128  ciphertext block, MSB = byte 0; sampled on the accepted start edge.
- w  input  128*(Nr+1)  expanded key schedule. Round key r = w[128*(Nr+1-r)-1 -: 128], so round key 0 occupies the MSBs. Must be held stable while busy=1.
- plain_text  output  128  decrypted block, registered; holds until the next completion or reset.
- busy  output  1  high from the accepted start until completion.
- done  output  1  single-cycle pulse when plain_text updates.

Behaviour:
- Reset (rst_n=0 at clock edge):
  - state=IDLE, plain_text=0, busy=0, done=0, round counter=0, state register=0.
  - Reset mid-operation aborts silently; no done pulse is issued.
- FSM states: IDLE, ROUND, FINAL.
- IDLE, start=1 at edge k:
  - state_reg <= cipher_text ^ rk[Nr]; round <= Nr-1; busy <= 1.
  - Next state is ROUND, or FINAL if Nr-1==0 (not reachable with legal Nr).
- ROUND at each edge:
  - state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ rk[round]); round <= round-1.
  - Go to FINAL after processing round==1.
- FINAL at edge:
  - plain_text <= InvSubBytes(InvShiftRows(state_reg)) ^ rk[0] (no InvMixColumns).
  - done <= 1; busy <= 0; go to IDLE.
- done is cleared on the following edge unless a new completion occurs (it cannot occur, because minimum latency is Nr cycles).
- Latency: start sampled at edge k -> plain_text valid and done=1 after edge k+Nr.
  - Nr=10: 10 cycles. Nr=12: 12. Nr=14: 14.
  - Throughput is one block per Nr+1 cycles: start may be accepted the edge after done because busy=0 then.
- start while busy=1: ignored. No queueing; cipher_text is not resampled.
- start held high continuously: a new block is accepted at each IDLE edge, i.e. back-to-back blocks with one IDLE cycle between them.
- Round counter width: clog2(Nr+1) bits, unsigned, never wraps below 0.
- InvSubBytes: combinational 256-entry inverse S-box, one instance per byte (16 instances).
- InvShiftRows: row r rotated right by r bytes, in column-major byte order.
- InvMixColumns: GF(2^8) multiply by {0e,0b,0d,09} using xtime chains, reduction polynomial 0x11b.
- rk index mux: a single 128-bit slice selected by the round counter. No combinational path from w to any output.
- Changes on cipher_text while busy=1 have no effect.

Test Plan:
- AES-128: key 000102030405060708090a0b0c0d0e0f expanded via KeyExpansion, cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a, start pulse -> done exactly 10 cycles later, plain_text 00112233445566778899aabbccddeeff, busy high for 10 cycles.
- AES-128 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, cipher_text 3925841d02dc09fbdc118597196a0b32 -> plain_text 3243f6a8885a308d313198a2e0370734.
- Nr=14, Nk=8: key 00..1f, cipher_text 8ea2b7ca516745bfeafc49904b496089 -> plain_text 00112233445566778899aabbccddeeff, done after 14 cycles. Also Nr=12, Nk=6: key 00..17, cipher_text dda97ca4864cdfe06eaf70a0ec0d7191 -> same plaintext after 12 cycles.
- Busy rejection: second start with a different cipher_text 3 cycles into a decryption -> ignored; single done; result equals the first block's plaintext.
- Reset mid-operation: rst_n=0 for 1 cycle at cycle 5 -> plain_text=0, busy=0, no done pulse. A subsequent start decrypts correctly in 10 cycles.
- Back-to-back: start held high for two blocks (69c4…, 3925…, each with its matching key schedule) -> done pulses 11 cycles apart, each plaintext correct, done never wider than 1 cycle.

Source files
------------

// File: rtl/inv_cipher_iter.sv
// inv_cipher_iter: iterative AES inverse cipher (FIPS-197 InvCipher), one round per clock.
// Round key r sits at w_i[128*(Nr+1-r)-1 -: 128]; round key 0 occupies the MSBs.
module inv_cipher_iter #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [127:0]          cipher_text_i,
  input  logic [128*(Nr+1)-1:0] w_i,
  output logic [127:0]          plain_text_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int RW = $clog2(Nr + 1);
  localparam logic [2047:0] ISBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
  if (Nr != Nk + 6) begin : g_cfg_err
    $error("inv_cipher_iter: Nr must equal Nk+6");
  end
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_e;
  state_e state_q, state_d;
  logic [RW-1:0] round_q, round_d, rk_idx;
  logic [127:0] s_q, s_d, pt_q, pt_d, isr, isb, ark, imc, rk;
  logic busy_q, busy_d, done_q, done_d;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? a : 8'h00);
  endfunction
  function automatic logic [31:0] imc_col(input logic [31:0] a);
    logic [7:0] b [4];
    logic [31:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) b[r] = a[31-8*r -: 8];
    for (int r = 0; r < 4; r++)
      o[31-8*r -: 8] = gm(b[r], 4'he) ^ gm(b[(r+1)%4], 4'hb) ^ gm(b[(r+2)%4], 4'hd) ^ gm(b[(r+3)%4], 4'h9);
    return o;
  endfunction
  // IDLE whitens with the last round key; later states index by the counter (0 in FINAL)
  assign rk_idx = state_q == IDLE ? RW'(Nr) : round_q;
  assign rk = w_i[128*(Nr-int'(rk_idx)) +: 128];
  for (genvar n = 0; n < 16; n++) begin : g_byte
    localparam int SRC = (((n / 4) - (n % 4) + 4) % 4) * 4 + (n % 4);
    assign isr[127-8*n -: 8] = s_q[127-8*SRC -: 8];
    assign isb[127-8*n -: 8] = ISBOX[11'd2047 - {isr[127-8*n -: 8], 3'b000} -: 8];
  end
  assign ark = isb ^ rk;
  for (genvar c = 0; c < 4; c++) begin : g_col
    assign imc[127-32*c -: 32] = imc_col(ark[127-32*c -: 32]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
      s_q <= '0;
      pt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      s_q <= s_d;
      pt_q <= pt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE  ? (start_i ? (Nr > 1 ? ROUND : FINAL) : IDLE)
            : state_q == ROUND ? (round_q == RW'(1) ? FINAL : ROUND) : IDLE;
  end
  always_comb begin
    s_d = (state_q == IDLE && start_i) ? cipher_text_i ^ rk : state_q == ROUND ? imc : s_q;
    round_d = (state_q == IDLE && start_i) ? RW'(Nr - 1)
            : (state_q == ROUND && round_q != '0) ? round_q - RW'(1) : round_q;
    pt_d = state_q == FINAL ? ark : pt_q;
    busy_d = state_d != IDLE;
    done_d = state_q == FINAL;
  end
  assign plain_text_o = pt_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
endmodule

// File: tb/tb_inv_cipher_iter.sv
// tb_inv_cipher_iter: checks AES-128/192/256 inverse cipher instances against FIPS vectors
// and against a forward-cipher reference model (decrypt must invert encrypt).
module tb_inv_cipher_iter;
  logic clk = 1'b0;
  logic rst_n;
  logic start [3];
  logic [127:0] ct [3];
  logic [1919:0] wf [3];
  logic [127:0] pt [3];
  logic busy [3];
  logic done [3];
  logic [7:0] sb [256];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  inv_cipher_iter #(.Nk(4), .Nr(10)) u10 (.clk(clk), .rst_n(rst_n), .start_i(start[0]), .cipher_text_i(ct[0]),
    .w_i(wf[0][1919 -: 1408]), .plain_text_o(pt[0]), .busy_o(busy[0]), .done_o(done[0]));
  inv_cipher_iter #(.Nk(6), .Nr(12)) u12 (.clk(clk), .rst_n(rst_n), .start_i(start[1]), .cipher_text_i(ct[1]),
    .w_i(wf[1][1919 -: 1664]), .plain_text_o(pt[1]), .busy_o(busy[1]), .done_o(done[1]));
  inv_cipher_iter #(.Nk(8), .Nr(14)) u14 (.clk(clk), .rst_n(rst_n), .start_i(start[2]), .cipher_text_i(ct[2]),
    .w_i(wf[2]), .plain_text_o(pt[2]), .busy_o(busy[2]), .done_o(done[2]));
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] b, input int k);
    return 8'((b << k) | (b >> (8 - k)));
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction
  function automatic logic [1919:0] kexp(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] wd [60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1919:0] o;
    rc = 8'h01;
    o = '0;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) wd[i] = key[255-32*i -: 32];
      else begin
        t = wd[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        wd[i] = wd[i-nk] ^ t;
      end
      o[1919-32*i -: 32] = wd[i];
    end
    return o;
  endfunction
  function automatic logic [127:0] enc(input logic [127:0] p, input logic [1919:0] ws, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int n = 0; n < 16; n++) s[n] = p[127-8*n -: 8] ^ ws[1919-8*n -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int n = 0; n < 16; n++) t[n] = sb[s[(((n / 4) + (n % 4)) % 4) * 4 + n % 4]];
      for (int n = 0; n < 16; n++)
        s[n] = (rd == nr) ? t[n] : gmul(t[4*(n/4) + n%4], 8'h02) ^ gmul(t[4*(n/4) + (n%4+1)%4], 8'h03)
                                   ^ t[4*(n/4) + (n%4+2)%4] ^ t[4*(n/4) + (n%4+3)%4];
      for (int n = 0; n < 16; n++) s[n] ^= ws[1919-128*rd-8*n -: 8];
    end
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = s[n];
    return o;
  endfunction
  function automatic logic [127:0] r128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic dec(input int d, input logic [127:0] c, input logic [127:0] e, input string tag);
    int lat;
    bit bz;
    ct[d] = c;
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    chk({tag, "_busy_start"}, 128'(busy[d]), 128'(1));
    lat = -1;
    bz = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      tick();
      if (done[d]) begin
        lat = j;
        break;
      end
      if (!busy[d]) bz = 1'b0;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(10 + 2 * d));
    chk({tag, "_busy_held"}, 128'(bz), 128'(1));
    chk({tag, "_pt"}, pt[d], e);
    chk({tag, "_busy_end"}, 128'(busy[d]), 128'(0));
    tick();
    chk({tag, "_done_pulse"}, 128'(done[d]), 128'(0));
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
  initial begin
    logic [1919:0] sa, sb_app;
    logic [127:0] p;
    logic [255:0] key;
    logic [7:0] inv;
    int nd, first, second, wide, d;
    bit prevd;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      ct[i] = '0;
      wf[i] = '0;
    end
    rst_n = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_pt%0d", i), pt[i], 128'h0);
      chk($sformatf("reset_busy%0d", i), 128'(busy[i]), 128'(0));
      chk($sformatf("reset_done%0d", i), 128'(done[i]), 128'(0));
    end
    rst_n = 1'b1;
    tick();
    sa = kexp({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    sb_app = kexp({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
    wf[0] = sa;
    dec(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, "aes128");
    wf[0] = sb_app;
    dec(0, 128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734, "appb");
    wf[1] = kexp({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 12);
    dec(1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 128'h00112233445566778899aabbccddeeff, "aes192");
    wf[2] = kexp(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    dec(2, 128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff, "aes256");
    // second start three cycles in must be ignored
    wf[0] = sa;
    ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (2) tick();
    ct[0] = 128'h3925841d02dc09fbdc118597196a0b32;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    nd = 0;
    first = -1;
    for (int j = 1; j <= 15; j++) begin
      tick();
      if (done[0]) begin
        nd++;
        if (first < 0) first = j;
      end
    end
    chk("busy_rej_ndone", 128'(nd), 128'(1));
    chk("busy_rej_latency", 128'(first), 128'(7));
    chk("busy_rej_pt", pt[0], 128'h00112233445566778899aabbccddeeff);
    // reset five cycles in aborts silently
    ct[0] = 128'h3925841d02dc09fbdc118597196a0b32;
    wf[0] = sb_app;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_pt", pt[0], 128'h0);
    chk("midrst_busy", 128'(busy[0]), 128'(0));
    chk("midrst_done", 128'(done[0]), 128'(0));
    nd = 0;
    for (int j = 0; j < 15; j++) begin
      tick();
      if (done[0]) nd++;
    end
    chk("midrst_no_done", 128'(nd), 128'(0));
    dec(0, 128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734, "after_rst");
    // start held high: two blocks back to back, schedule swapped while idle
    wf[0] = sa;
    ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    start[0] = 1'b1;
    tick();
    nd = 0;
    first = -1;
    second = -1;
    wide = 0;
    prevd = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      tick();
      if (done[0] && prevd) wide++;
      prevd = done[0];
      if (done[0]) begin
        nd++;
        if (nd == 1) begin
          first = j;
          chk("b2b_pt1", pt[0], 128'h00112233445566778899aabbccddeeff);
          wf[0] = sb_app;
          ct[0] = 128'h3925841d02dc09fbdc118597196a0b32;
        end else if (nd == 2) begin
          second = j;
          chk("b2b_pt2", pt[0], 128'h3243f6a8885a308d313198a2e0370734);
          start[0] = 1'b0;
        end
      end
    end
    start[0] = 1'b0;
    chk("b2b_first", 128'(first), 128'(10));
    chk("b2b_gap", 128'(second - first), 128'(11));
    chk("b2b_ndone", 128'(nd), 128'(2));
    chk("b2b_wide", 128'(wide), 128'(0));
    // random blocks: decrypt of the model's encryption must return the plaintext
    for (int i = 0; i < 9; i++) begin
      d = i % 3;
      key = {r128(), r128()};
      p = r128();
      wf[d] = kexp(key, 4 + 2 * d, 10 + 2 * d);
      dec(d, enc(p, wf[d], 10 + 2 * d), p, $sformatf("rand%0d", i));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
